// File: rtl/local_inject_ni_pkg.sv
// Shared constants and helpers for the local injection network interface.
// Flit geometry matches the router port and its embedded Time field.
package local_inject_ni_pkg;

    localparam int WIDTH_PORT   = 32;
    localparam int POS_TIME_LSB = 8;
    localparam int WIDTH_TIME   = 8;

    localparam int NUM_LINKS    = 4;

    // Number of router input links carrying a flit this cycle.
    function automatic logic [2:0] busy_count(input logic [NUM_LINKS-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/local_inject_ni_flit_fifo.sv
// Register-based synchronous flit FIFO with async active-low reset.
// The head entry is presented continuously on dout; the fill level is exported.
module flit_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/local_inject_ni.sv
// Injection NI in front of the router's local input: queues core flits, injects one
// per cycle into a free router slot with the current timestamp, and flags starvation.
module local_inject_ni
    import local_inject_ni_pkg::*;
#(
    parameter int FLIT_W       = WIDTH_PORT,
    parameter int DEPTH        = 8,
    parameter int TIME_LSB     = POS_TIME_LSB,
    parameter int TIME_W       = WIDTH_TIME,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      core_valid,
    output logic                      core_ready,
    input  logic [FLIT_W-1:0]         core_flit,
    input  logic                      inj_en,
    input  logic [FLIT_W-1:0]         linkW,
    input  logic [FLIT_W-1:0]         linkE,
    input  logic [FLIT_W-1:0]         linkS,
    input  logic [FLIT_W-1:0]         linkN,
    output logic [FLIT_W-1:0]         doutLocal,
    output logic                      starve,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      err_zero
);

    localparam int BW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(STARVE_LIMIT);

    logic                 ready_q;
    logic [TIME_W-1:0]    ts_q;
    logic [BW-1:0]        blk_q, blk_d;
    logic                 starve_q;
    logic                 err_zero_q, err_zero_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FLIT_W-1:0]    head;
    logic                 accept;
    logic                 push;
    logic                 fire;
    logic                 slot_ok;
    logic [FLIT_W-1:0]    links [NUM_LINKS];
    logic [NUM_LINKS-1:0] link_v;
    logic [FLIT_W-1:0]    stamped;

    assign links[0] = linkW;
    assign links[1] = linkE;
    assign links[2] = linkS;
    assign links[3] = linkN;

    for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_link_v
        assign link_v[gi] = |links[gi];
    end

    // The router has five inputs and four outputs, so one slot is free unless all links carry flits.
    assign slot_ok = (busy_count(link_v) < 3'd4);

    // ready_q keeps the FIFO closed while reset is held and opens it on the first edge after release.
    assign core_ready = ready_q && !fifo_full;
    assign accept     = core_valid && core_ready;
    assign push       = accept && (|core_flit);
    assign fire       = !fifo_empty && inj_en && slot_ok;

    flit_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (core_flit),
        .pop   (fire),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_comb begin
        stamped                       = head;
        stamped[TIME_LSB +: TIME_W]   = ts_q;
        doutLocal                     = fire ? stamped : '0;
    end

    always_comb begin
        blk_d = blk_q;
        if (fifo_empty || fire) begin
            blk_d = '0;
        end else if (inj_en && !slot_ok && (blk_q != BLK_MAX)) begin
            blk_d = blk_q + BW'(1);
        end
    end

    assign err_zero_d = err_zero_q || (accept && !(|core_flit));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q    <= 1'b0;
            ts_q       <= '0;
            blk_q      <= '0;
            starve_q   <= 1'b0;
            err_zero_q <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            ts_q       <= ts_q + TIME_W'(1);
            blk_q      <= blk_d;
            starve_q   <= (blk_d == BLK_MAX);
            err_zero_q <= err_zero_d;
        end
    end

    assign starve   = starve_q;
    assign err_zero = err_zero_q;

endmodule

// File: tb/tb_local_inject_ni.sv
// Directed bench for local_inject_ni: a slot-check vector table plus hand sequences for
// reset, link saturation/starvation, full/wrap ordering, zero flits and timestamp wrap.
module tb_local_inject_ni;

    logic        clk;
    logic        reset;
    logic        core_valid;
    logic        core_ready;
    logic [31:0] core_flit;
    logic        inj_en;
    logic [31:0] linkW, linkE, linkS, linkN;
    logic [31:0] doutLocal;
    logic        starve;
    logic [3:0]  occupancy;
    logic        err_zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_ts;

    local_inject_ni dut (
        .clk        (clk),
        .reset      (reset),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_flit  (core_flit),
        .inj_en     (inj_en),
        .linkW      (linkW),
        .linkE      (linkE),
        .linkS      (linkS),
        .linkN      (linkN),
        .doutLocal  (doutLocal),
        .starve     (starve),
        .occupancy  (occupancy),
        .err_zero   (err_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference free-running timestamp: number of edges since reset release, mod 256.
    always @(posedge clk or negedge reset) begin
        if (!reset) model_ts <= 8'd0;
        else        model_ts <= model_ts + 8'd1;
    end

    typedef struct {
        logic        push;
        logic [31:0] flit;
        logic        inj;
        logic [3:0]  busy;   // {W,E,S,N}
        logic        fire;
        logic [31:0] head;
        int          occ;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] stamp(input logic [31:0] f, input logic [7:0] t);
        logic [31:0] r;
        r        = f;
        r[15:8]  = t;
        return r;
    endfunction

    function automatic logic [31:0] mk(input int i);
        return {16'(i + 1), 8'h55, 8'hC3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_links(input logic [3:0] busy);
        linkW = busy[3] ? 32'h0000_0011 : 32'h0;
        linkE = busy[2] ? 32'h0000_2200 : 32'h0;
        linkS = busy[1] ? 32'h0033_0000 : 32'h0;
        linkN = busy[0] ? 32'h4400_0000 : 32'h0;
    endtask

    logic [31:0] sb_q[$];
    logic [31:0] exp_flit;
    logic [31:0] p_flit, q_flit;
    int          sent, recv;

    initial begin
        vecs[0]  = '{1'b1, 32'hAAAA_00A1, 1'b1, 4'b0000, 1'b0, 32'h0,         0};
        vecs[1]  = '{1'b1, 32'hBBBB_00B2, 1'b1, 4'b0000, 1'b1, 32'hAAAA_00A1, 1};
        vecs[2]  = '{1'b1, 32'hCCCC_00C3, 1'b1, 4'b0000, 1'b1, 32'hBBBB_00B2, 1};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 4'b0000, 1'b1, 32'hCCCC_00C3, 1};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 4'b0000, 1'b0, 32'h0,         0};
        vecs[5]  = '{1'b1, 32'hDDDD_00D4, 1'b1, 4'b1111, 1'b0, 32'h0,         0};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 4'b1111, 1'b0, 32'h0,         1};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0,         1};
        vecs[8]  = '{1'b1, 32'hEEEE_00E5, 1'b1, 4'b0111, 1'b1, 32'hDDDD_00D4, 1};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 4'b1011, 1'b1, 32'hEEEE_00E5, 1};
        vecs[10] = '{1'b1, 32'h1234_00F6, 1'b1, 4'b1101, 1'b0, 32'h0,         0};
        vecs[11] = '{1'b0, 32'h0,         1'b1, 4'b1110, 1'b1, 32'h1234_00F6, 1};
        vecs[12] = '{1'b0, 32'h0,         1'b1, 4'b0000, 1'b0, 32'h0,         0};

        reset      = 1'b0;
        core_valid = 1'b0;
        core_flit  = 32'h0;
        inj_en     = 1'b0;
        set_links(4'b0000);

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_occ",   32'(occupancy),  32'd0);
        chk("rst_dout",  doutLocal,       32'h0);
        chk("rst_starve",32'(starve),     32'd0);
        chk("rst_err",   32'(err_zero),   32'd0);
        chk("rst_ready", 32'(core_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_rst", 32'(core_ready), 32'd1);

        // ---- test 1: reset mid-stream ----
        for (int i = 0; i < 3; i++) begin
            core_valid = 1'b1;
            core_flit  = 32'h7700_0001 + 32'(i);
            @(negedge clk);
        end
        core_valid = 1'b0;
        #1;
        chk("t1_occ3", 32'(occupancy), 32'd3);
        inj_en = 1'b1;
        #1;
        chk("t1_pre_dout", doutLocal, stamp(32'h7700_0001, model_ts));
        #1;
        reset = 1'b0;
        #1;
        chk("t1_async_occ",    32'(occupancy),  32'd0);
        chk("t1_async_dout",   doutLocal,       32'h0);
        chk("t1_async_starve", 32'(starve),     32'd0);
        chk("t1_async_ready",  32'(core_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("t1_post_dout", doutLocal,       32'h0);
            chk("t1_post_occ",  32'(occupancy),  32'd0);
        end
        $display("reset mid-stream sequence done");

        // ---- table: basic inject and slot check ----
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            core_valid = vecs[v].push;
            core_flit  = vecs[v].flit;
            inj_en     = vecs[v].inj;
            set_links(vecs[v].busy);
            #1;
            exp_flit = vecs[v].fire ? stamp(vecs[v].head, model_ts) : 32'h0;
            chk("vec_dout",  doutLocal,       exp_flit);
            chk("vec_occ",   32'(occupancy),  32'(vecs[v].occ));
            chk("vec_ready", 32'(core_ready), 32'd1);
            $display("vec %0d: busy=%b dout=%h occ=%0d", v, vecs[v].busy, doutLocal, occupancy);
        end
        @(negedge clk);
        core_valid = 1'b0;
        set_links(4'b0000);

        // ---- test 3: link saturation and starvation ----
        inj_en     = 1'b0;
        core_valid = 1'b1;
        core_flit  = 32'h5A5A_0042;
        @(negedge clk);
        core_valid = 1'b0;
        inj_en     = 1'b1;
        set_links(4'b1111);
        for (int k = 1; k <= 20; k++) begin
            #1;
            chk("t3_blocked_dout", doutLocal, 32'h0);
            chk("t3_starve", 32'(starve), (k >= 17) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        set_links(4'b1110);
        #1;
        chk("t3_release_dout",   doutLocal,   stamp(32'h5A5A_0042, model_ts));
        chk("t3_release_starve", 32'(starve), 32'd1);
        @(negedge clk);
        #1;
        chk("t3_starve_fall", 32'(starve),    32'd0);
        chk("t3_after_dout",  doutLocal,      32'h0);
        chk("t3_after_occ",   32'(occupancy), 32'd0);
        set_links(4'b0000);
        $display("saturation sequence done");

        // ---- test 4: full and pointer wrap ----
        inj_en = 1'b0;
        sent   = 0;
        recv   = 0;
        for (int c = 0; c < 200 && recv < 24; c++) begin
            @(negedge clk);
            if (!inj_en && sent == 8) begin
                #1;
                chk("t4_full_ready", 32'(core_ready), 32'd0);
                chk("t4_full_occ",   32'(occupancy),  32'd8);
                inj_en = 1'b1;
            end
            core_valid = (sent < 24);
            core_flit  = mk(sent);
            #1;
            chk("t4_occ", 32'(occupancy), 32'(sb_q.size()));
            if (inj_en && sb_q.size() > 0) begin
                exp_flit = stamp(sb_q.pop_front(), model_ts);
                chk("t4_dout", doutLocal, exp_flit);
                $display("t4 flit %0d out: %h", recv, doutLocal);
                recv++;
            end
            if (core_valid && core_ready) begin
                sb_q.push_back(core_flit);
                sent++;
            end
        end
        chk("t4_recv_count", 32'(recv), 32'd24);
        core_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_drained", 32'(occupancy), 32'd0);

        // ---- test 5: zero flit, then timestamp wrap ----
        inj_en     = 1'b1;
        core_valid = 1'b1;
        core_flit  = 32'h0;
        #1;
        chk("t5_zero_ready", 32'(core_ready), 32'd1);
        @(negedge clk);
        core_valid = 1'b0;
        #1;
        chk("t5_zero_occ",  32'(occupancy), 32'd0);
        chk("t5_zero_dout", doutLocal,      32'h0);
        chk("t5_err_set",   32'(err_zero),  32'd1);

        inj_en = 1'b0;
        p_flit = 32'hCAFE_0011;
        q_flit = 32'hBEEF_0022;
        core_valid = 1'b1;
        core_flit  = p_flit;
        @(negedge clk);
        core_flit  = q_flit;
        @(negedge clk);
        core_valid = 1'b0;
        for (int c = 0; c < 600 && model_ts != 8'hFE; c++) @(negedge clk);
        @(negedge clk);
        inj_en = 1'b1;
        #1;
        chk("t5_stamp_max",  doutLocal, {p_flit[31:16], 8'hFF, p_flit[7:0]});
        @(negedge clk);
        #1;
        chk("t5_stamp_zero", doutLocal, {q_flit[31:16], 8'h00, q_flit[7:0]});
        @(negedge clk);
        #1;
        chk("t5_err_sticky", 32'(err_zero),  32'd1);
        chk("t5_final_occ",  32'(occupancy), 32'd0);
        $display("zero flit / timestamp wrap sequence done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
